// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble, PC redirect
// capture and a saturating bubble counter. Optional skid slot: define PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 148,
    parameter int CTRL_W = 17,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_redirect,
    input  logic [PC_W-1:0]   in_redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_r, valid_nxt_s;
    logic [DATA_W-1:0] data_r, data_nxt_s;
    logic [CTRL_W-1:0] ctrl_r, ctrl_nxt_s;
    logic [PC_W-1:0]   pc_r, pc_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic [PC_W-1:0]   in_pc_sel_s;

    assign in_pc_sel_s = in_redirect ? in_redirect_pc : in_pc;
    assign in_fire_s   = in_valid & in_ready;
    assign out_fire_s  = valid_r & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid_r, skid_valid_nxt_s;
    logic [DATA_W-1:0] skid_data_r, skid_data_nxt_s;
    logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_nxt_s;
    logic [PC_W-1:0]   skid_pc_r, skid_pc_nxt_s;

    // Registered ready: the skid slot absorbs the one entry that may arrive during a stall.
    assign in_ready = ~skid_valid_r;

    // Next state for main and skid entries; skid always drains to main before new input.
    always_comb begin
        valid_nxt_s      = valid_r;
        data_nxt_s       = data_r;
        ctrl_nxt_s       = ctrl_r;
        pc_nxt_s         = pc_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        skid_ctrl_nxt_s  = skid_ctrl_r;
        skid_pc_nxt_s    = skid_pc_r;
        if (flush) begin
            valid_nxt_s      = 1'b0;
            data_nxt_s       = {DATA_W{1'b0}};
            ctrl_nxt_s       = {CTRL_W{1'b0}};
            pc_nxt_s         = {PC_W{1'b0}};
            skid_valid_nxt_s = 1'b0;
            skid_data_nxt_s  = {DATA_W{1'b0}};
            skid_ctrl_nxt_s  = {CTRL_W{1'b0}};
            skid_pc_nxt_s    = {PC_W{1'b0}};
        end else if (out_fire_s) begin
            if (skid_valid_r) begin
                valid_nxt_s      = 1'b1;
                data_nxt_s       = skid_data_r;
                ctrl_nxt_s       = skid_ctrl_r;
                pc_nxt_s         = skid_pc_r;
                skid_valid_nxt_s = 1'b0;
            end else if (in_fire_s) begin
                valid_nxt_s = 1'b1;
                data_nxt_s  = in_data;
                ctrl_nxt_s  = in_ctrl;
                pc_nxt_s    = in_pc_sel_s;
            end else begin
                valid_nxt_s = 1'b0;
                ctrl_nxt_s  = {CTRL_W{1'b0}};
            end
        end else if (in_fire_s) begin
            if (valid_r) begin
                skid_valid_nxt_s = 1'b1;
                skid_data_nxt_s  = in_data;
                skid_ctrl_nxt_s  = in_ctrl;
                skid_pc_nxt_s    = in_pc_sel_s;
            end else begin
                valid_nxt_s = 1'b1;
                data_nxt_s  = in_data;
                ctrl_nxt_s  = in_ctrl;
                pc_nxt_s    = in_pc_sel_s;
            end
        end else begin
            valid_nxt_s      = valid_r;
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Skid slot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_valid_r <= 1'b0;
            skid_data_r  <= {DATA_W{1'b0}};
            skid_ctrl_r  <= {CTRL_W{1'b0}};
            skid_pc_r    <= {PC_W{1'b0}};
        end else begin
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            skid_ctrl_r  <= skid_ctrl_nxt_s;
            skid_pc_r    <= skid_pc_nxt_s;
        end
    end
`else
    // Ready also reads high during flush since any offered entry is discarded anyway.
    assign in_ready = flush | ~valid_r | out_ready;

    // Next state for the single entry: flush, then load, then drain.
    always_comb begin
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        ctrl_nxt_s  = ctrl_r;
        pc_nxt_s    = pc_r;
        if (flush) begin
            valid_nxt_s = 1'b0;
            data_nxt_s  = {DATA_W{1'b0}};
            ctrl_nxt_s  = {CTRL_W{1'b0}};
            pc_nxt_s    = {PC_W{1'b0}};
        end else if (in_fire_s) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = in_data;
            ctrl_nxt_s  = in_ctrl;
            pc_nxt_s    = in_pc_sel_s;
        end else if (out_fire_s) begin
            valid_nxt_s = 1'b0;
            ctrl_nxt_s  = {CTRL_W{1'b0}};
        end else begin
            valid_nxt_s = valid_r;
            ctrl_nxt_s  = ctrl_r;
        end
    end
`endif

    // Saturating count of cycles where downstream was ready but the stage was empty.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (out_ready && !valid_r && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Main entry and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            data_r  <= {DATA_W{1'b0}};
            ctrl_r  <= {CTRL_W{1'b0}};
            pc_r    <= {PC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign out_valid  = valid_r;
    assign out_data   = data_r;
    assign out_ctrl   = ctrl_r;
    assign out_pc     = pc_r;
    assign bubble_cnt = cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (default build, no skid slot).
module tb_pipe_stage_reg;

    localparam int DATA_W = 148;
    localparam int CTRL_W = 17;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [PC_W-1:0]   in_pc;
    logic              in_redirect;
    logic [PC_W-1:0]   in_redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [PC_W-1:0]   out_pc;
    logic [CNT_W-1:0]  bubble_cnt;

    int total_cnt = 0;
    int bad_cnt   = 0;

    localparam logic [DATA_W-1:0] D1 = {20'hABCDE, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
    localparam logic [DATA_W-1:0] D2 = {20'h13579, 64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_1234_5678};

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .PC_W(PC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_pc(in_pc), .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .out_pc(out_pc), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [CTRL_W-1:0] c, input logic [PC_W-1:0] p, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_pc    = p;
        in_data  = d;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        in_pc = '0; in_redirect = 1'b0; in_redirect_pc = '0; out_ready = 1'b0;
        step();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ctrl", out_ctrl, 17'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_data", out_data, 148'h0);
        chk("rst_cnt", bubble_cnt, 16'h0);
        chk("rst_ready", in_ready, 1'b1);
        step();
        reset = 1'b1;

        // Idle with downstream ready: 10 bubble cycles.
        out_ready = 1'b1;
        repeat (10) step();
        chk("bubble10", bubble_cnt, 16'd10);

        // Basic load, 1-cycle latency.
        offer(17'h1A5, 32'h400, D1);
        step();
        chk("load_valid", out_valid, 1'b1);
        chk("load_ctrl", out_ctrl, 17'h1A5);
        chk("load_pc", out_pc, 32'h400);
        chk("load_data", out_data, D1);
        chk("load_cnt", bubble_cnt, 16'd11);

        // Redirect capture with back-to-back replace.
        offer(17'h0F0, 32'h408, D2);
        in_redirect = 1'b1;
        in_redirect_pc = 32'h8000_0004;
        step();
        in_redirect = 1'b0;
        chk("redir_pc", out_pc, 32'h8000_0004);
        chk("redir_ctrl", out_ctrl, 17'h0F0);
        chk("redir_valid", out_valid, 1'b1);

        // Stall for 3 cycles: hold, in_ready low, new entry not taken.
        offer(17'h333, 32'h500, D1);
        out_ready = 1'b0;
        #1;
        chk("stall_ready", in_ready, 1'b0);
        repeat (3) step();
        chk("stall_ctrl", out_ctrl, 17'h0F0);
        chk("stall_pc", out_pc, 32'h8000_0004);
        chk("stall_data", out_data, D2);
        chk("stall_ready2", in_ready, 1'b0);
        chk("stall_cnt", bubble_cnt, 16'd11);

        // Drain with no new entry: valid/ctrl clear, data/pc hold.
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("drain_ready", in_ready, 1'b1);
        step();
        chk("drain_valid", out_valid, 1'b0);
        chk("drain_ctrl", out_ctrl, 17'h0);
        chk("drain_pc", out_pc, 32'h8000_0004);
        chk("drain_data", out_data, D2);

        // Load then flush while a new entry is offered.
        offer(17'h011, 32'h600, D1);
        step();
        chk("pre_flush_valid", out_valid, 1'b1);
        flush = 1'b1;
        offer(17'h022, 32'h700, D2);
        out_ready = 1'b0;
        #1;
        chk("flush_ready", in_ready, 1'b1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", out_ctrl, 17'h0);
        chk("flush_pc", out_pc, 32'h0);
        chk("flush_data", out_data, 148'h0);
        out_ready = 1'b1;
        step();
        chk("post_flush_valid", out_valid, 1'b0);
        chk("post_flush_ctrl", out_ctrl, 17'h0);
        chk("post_flush_cnt", bubble_cnt, 16'd13);

        // Reset asserted mid-stall.
        offer(17'h055, 32'h900, D1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        chk("midstall_valid", out_valid, 1'b1);
        chk("midstall_cnt", bubble_cnt, 16'd14);
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_ctrl", out_ctrl, 17'h0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_data", out_data, 148'h0);
        chk("arst_cnt", bubble_cnt, 16'h0);
        chk("arst_ready", in_ready, 1'b1);
        step();
        reset = 1'b1;

        // Saturation after 2**CNT_W+5 bubble cycles.
        out_ready = 1'b1;
        repeat ((1 << CNT_W) + 5) step();
        chk("sat_cnt", bubble_cnt, 16'hFFFF);
        chk("sat_valid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
